// File: rtl/acc_obi_arbiter_if.sv
// OBI bundle between the accelerator channels, the arbiter and the X-HEEP external master port.
// The arbiter takes the slave view; the environment driving channels and the X-HEEP side takes the master view.
interface acc_obi_arbiter_if #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
);
  logic [NCH-1:0]        ch_req_i;
  logic [NCH-1:0]        ch_gnt_o;
  logic [NCH*AW-1:0]     ch_addr_i;
  logic [NCH-1:0]        ch_we_i;
  logic [NCH*DW/8-1:0]   ch_be_i;
  logic [NCH*DW-1:0]     ch_wdata_i;
  logic [NCH-1:0]        ch_rvalid_o;
  logic [NCH*DW-1:0]     ch_rdata_o;
  logic                  m_req_o;
  logic                  m_gnt_i;
  logic [AW-1:0]         m_addr_o;
  logic                  m_we_o;
  logic [DW/8-1:0]       m_be_o;
  logic [DW-1:0]         m_wdata_o;
  logic                  m_rvalid_i;
  logic [DW-1:0]         m_rdata_i;
  logic [$clog2(MAX_OUT):0] out_cnt_o;
  logic                  err_o;

  modport slave (
    input  ch_req_i, ch_addr_i, ch_we_i, ch_be_i, ch_wdata_i,
    input  m_gnt_i, m_rvalid_i, m_rdata_i,
    output ch_gnt_o, ch_rvalid_o, ch_rdata_o,
    output m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    output out_cnt_o, err_o
  );

  modport master (
    output ch_req_i, ch_addr_i, ch_we_i, ch_be_i, ch_wdata_i,
    output m_gnt_i, m_rvalid_i, m_rdata_i,
    input  ch_gnt_o, ch_rvalid_o, ch_rdata_o,
    input  m_req_o, m_addr_o, m_we_o, m_be_o, m_wdata_o,
    input  out_cnt_o, err_o
  );
endinterface

// File: rtl/acc_obi_arbiter.sv
// Round-robin OBI arbiter funnelling NCH accelerator masters into one X-HEEP port, with an ID FIFO routing responses back.
// Define ACC_OBI_ARBITER_PRIO0_EN to give channel 0 absolute priority whenever no request is locked.
module acc_obi_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  acc_obi_arbiter_if.slave bus
);

  localparam int IW = $clog2(NCH);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam int BW = DW / 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [IW-1:0] CH_LAST = IW'(NCH - 1);

  logic [IW-1:0] rr_q;
  logic          lock_q;
  logic [IW-1:0] lock_ch_q;
  logic [IW-1:0] id_mem [MAX_OUT];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  logic [IW-1:0] sel;
  logic [IW-1:0] head;
  logic          m_req;
  logic          push;
  logic          pop;

  function automatic logic [IW-1:0] next_ch(input logic [IW-1:0] ch);
    return (ch == CH_LAST) ? '0 : ch + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping past the last channel.
  function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_ch(idx);
    end
    return pick;
  endfunction

  always_comb begin
    sel = '0;
    if (lock_q)
      sel = lock_ch_q;
`ifdef ACC_OBI_ARBITER_PRIO0_EN
    else if (bus.ch_req_i[0])
      sel = '0;
`endif
    else
      sel = rr_pick(bus.ch_req_i, rr_q);
  end

  // A full FIFO blocks new requests even when a pop lands in the same cycle.
  assign m_req = !rst_i && (bus.ch_req_i != '0) && (cnt_q != CNT_MAX);
  assign push  = m_req && bus.m_gnt_i;
  assign pop   = !rst_i && bus.m_rvalid_i && (cnt_q != '0);
  assign head  = id_mem[rptr_q];

  always_comb begin
    bus.m_req_o     = m_req;
    bus.m_addr_o    = '0;
    bus.m_we_o      = 1'b0;
    bus.m_be_o      = '0;
    bus.m_wdata_o   = '0;
    bus.ch_gnt_o    = '0;
    bus.ch_rvalid_o = '0;
    bus.ch_rdata_o  = '0;
    if (m_req) begin
      bus.m_addr_o      = bus.ch_addr_i[int'(sel)*AW +: AW];
      bus.m_we_o        = bus.ch_we_i[sel];
      bus.m_be_o        = bus.ch_be_i[int'(sel)*BW +: BW];
      bus.m_wdata_o     = bus.ch_wdata_i[int'(sel)*DW +: DW];
      bus.ch_gnt_o[sel] = bus.m_gnt_i;
    end
    if (pop) begin
      bus.ch_rvalid_o[head]               = 1'b1;
      bus.ch_rdata_o[int'(head)*DW +: DW] = bus.m_rdata_i;
    end
  end

  assign bus.out_cnt_o = cnt_q;
  assign bus.err_o     = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
        lock_q <= 1'b0;
`ifdef ACC_OBI_ARBITER_PRIO0_EN
        if (sel != '0)
          rr_q <= next_ch(sel);
`else
        rr_q <= next_ch(sel);
`endif
      end else if (m_req) begin
        lock_q    <= 1'b1;
        lock_ch_q <= sel;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (pop && !push)
        cnt_q <= cnt_q - 1'b1;
      if (bus.m_rvalid_i && (cnt_q == '0))
        err_q <= 1'b1;
    end
  end

  // ID storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push)
      id_mem[wptr_q] <= sel;
  end

endmodule

// File: tb/tb_acc_obi_arbiter.sv
// Self-checking bench for acc_obi_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_acc_obi_arbiter;
  localparam int NCH     = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_OUT) + 1;
`ifdef ACC_OBI_ARBITER_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acc_obi_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) bus ();

  acc_obi_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int rr_m;
  int lock_m;
  int q_m[$];
  bit err_m;

  int                  exp_sel;
  logic                exp_mreq;
  logic [NCH-1:0]      exp_gnt;
  logic [NCH-1:0]      exp_rvalid;
  logic [NCH*DW-1:0]   exp_rdata;
  logic [AW-1:0]       exp_addr;
  logic                exp_we;
  logic [DW/8-1:0]     exp_be;
  logic [DW-1:0]       exp_wdata;
  logic [CW-1:0]       exp_cnt;
  logic                exp_err;

  function automatic logic [AW-1:0] addr_of(input int k);
    return AW'(32'h1000_0000 + k * 32'h100);
  endfunction

  function automatic void model_eval();
    int n;
    int s;
    int c;
    n = q_m.size();
    s = -1;
    if (lock_m >= 0) s = lock_m;
    else if (PRIO && bus.ch_req_i[0]) s = 0;
    else begin
      for (int i = 0; i < NCH; i++) begin
        c = (rr_m + i) % NCH;
        if (s < 0 && bus.ch_req_i[c]) s = c;
      end
    end
    exp_sel    = s;
    exp_mreq   = (bus.ch_req_i != '0) && (n < MAX_OUT);
    exp_gnt    = '0;
    exp_addr   = '0;
    exp_we     = 1'b0;
    exp_be     = '0;
    exp_wdata  = '0;
    if (exp_mreq) begin
      exp_addr  = bus.ch_addr_i[s*AW +: AW];
      exp_we    = bus.ch_we_i[s];
      exp_be    = bus.ch_be_i[s*(DW/8) +: DW/8];
      exp_wdata = bus.ch_wdata_i[s*DW +: DW];
      if (bus.m_gnt_i) exp_gnt[s] = 1'b1;
    end
    exp_rvalid = '0;
    exp_rdata  = '0;
    if (bus.m_rvalid_i && n > 0) begin
      exp_rvalid[q_m[0]]          = 1'b1;
      exp_rdata[q_m[0]*DW +: DW]  = bus.m_rdata_i;
    end
    exp_cnt = CW'(n);
    exp_err = err_m;
  endfunction

  function automatic void model_commit();
    int n;
    n = q_m.size();
    if (bus.m_rvalid_i && n == 0) err_m = 1'b1;
    if (bus.m_rvalid_i && n > 0) q_m.delete(0);
    if (exp_mreq && bus.m_gnt_i) begin
      q_m.push_back(exp_sel);
      lock_m = -1;
      if (!(PRIO && exp_sel == 0)) rr_m = (exp_sel + 1) % NCH;
    end else if (exp_mreq) begin
      lock_m = exp_sel;
    end
  endfunction

  task automatic drive(input logic [NCH-1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
    @(negedge clk);
    bus.ch_req_i   = req;
    bus.m_gnt_i    = gnt;
    bus.m_rvalid_i = rv;
    bus.m_rdata_i  = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.ch_req_i   = '0;
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = '0;
    bus.ch_we_i    = '1;
    bus.ch_be_i    = '1;
    for (int k = 0; k < NCH; k++) begin
      bus.ch_addr_i[k*AW +: AW]  = addr_of(k);
      bus.ch_wdata_i[k*DW +: DW] = DW'(32'hC0DE_0000 + k);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m   = 0;
    lock_m = -1;
    q_m.delete();
    err_m  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive('1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    checks++; if (bus.m_req_o !== 1'b0) begin errors++; $display("FAIL rst_mreq got %0h exp 0", bus.m_req_o); end
    checks++; if (bus.ch_gnt_o !== '0) begin errors++; $display("FAIL rst_gnt got %0h exp 0", bus.ch_gnt_o); end
    checks++; if (bus.ch_rvalid_o !== '0) begin errors++; $display("FAIL rst_rvalid got %0h exp 0", bus.ch_rvalid_o); end
    checks++; if (bus.m_addr_o !== '0) begin errors++; $display("FAIL rst_addr got %0h exp 0", bus.m_addr_o); end
    checks++; if (bus.out_cnt_o !== '0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.out_cnt_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %0h exp 0", bus.err_o); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 1'b1, i > 0, 32'h0);
      exp = (PRIO || (i % 2) == 0) ? 2'b01 : 2'b10;
      checks++; if (bus.ch_gnt_o !== exp) begin errors++; $display("FAIL rr_gnt%0d got %0h exp %0h", i, bus.ch_gnt_o, exp); end
      checks++; if (bus.m_addr_o !== addr_of(exp == 2'b01 ? 0 : 1)) begin errors++; $display("FAIL rr_addr%0d got %0h", i, bus.m_addr_o); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int cyc = 1; cyc <= 3; cyc++) begin
      drive(cyc == 1 ? 2'b10 : 2'b11, 1'b0, 1'b0, 32'h0);
      checks++; if (bus.m_addr_o !== addr_of(1)) begin errors++; $display("FAIL lock_addr%0d got %0h exp %0h", cyc, bus.m_addr_o, addr_of(1)); end
      checks++; if (bus.m_req_o !== 1'b1) begin errors++; $display("FAIL lock_mreq%0d got %0h exp 1", cyc, bus.m_req_o); end
    end
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.ch_gnt_o !== 2'b10) begin errors++; $display("FAIL lock_gnt4 got %0h exp 2", bus.ch_gnt_o); end
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.ch_gnt_o !== 2'b01) begin errors++; $display("FAIL lock_gnt5 got %0h exp 1", bus.ch_gnt_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < MAX_OUT; i++) drive(2'b01, 1'b1, 1'b0, 32'h0);
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.out_cnt_o !== CW'(MAX_OUT)) begin errors++; $display("FAIL full_cnt got %0d exp %0d", bus.out_cnt_o, MAX_OUT); end
    checks++; if (bus.m_req_o !== 1'b0) begin errors++; $display("FAIL full_mreq got %0h exp 0", bus.m_req_o); end
    checks++; if (bus.ch_gnt_o !== '0) begin errors++; $display("FAIL full_gnt got %0h exp 0", bus.ch_gnt_o); end
    drive(2'b01, 1'b1, 1'b1, 32'h5A5A_0001);
    checks++; if (bus.m_req_o !== 1'b0) begin errors++; $display("FAIL full_pop_mreq got %0h exp 0", bus.m_req_o); end
    checks++; if (bus.ch_rvalid_o !== 2'b01) begin errors++; $display("FAIL full_pop_rvalid got %0h exp 1", bus.ch_rvalid_o); end
    drive(2'b01, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.m_req_o !== 1'b1) begin errors++; $display("FAIL full_after_mreq got %0h exp 1", bus.m_req_o); end
    checks++; if (bus.out_cnt_o !== CW'(MAX_OUT - 1)) begin errors++; $display("FAIL full_after_cnt got %0d exp %0d", bus.out_cnt_o, MAX_OUT - 1); end
  endtask

  task automatic test_routing();
    do_reset();
    @(negedge clk);
    bus.ch_addr_i[AW +: AW] = 32'h2000_0000;
    bus.ch_we_i[1]          = 1'b0;
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.ch_gnt_o !== 2'b10) begin errors++; $display("FAIL route_gnt1 got %0h exp 2", bus.ch_gnt_o); end
    checks++; if (bus.m_addr_o !== 32'h2000_0000) begin errors++; $display("FAIL route_addr got %0h exp 20000000", bus.m_addr_o); end
    checks++; if (bus.m_we_o !== 1'b0) begin errors++; $display("FAIL route_we got %0h exp 0", bus.m_we_o); end
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.ch_gnt_o !== 2'b01) begin errors++; $display("FAIL route_gnt0 got %0h exp 1", bus.ch_gnt_o); end
    drive(2'b00, 1'b0, 1'b1, 32'hAAAA_5555);
    checks++; if (bus.ch_rvalid_o !== 2'b10) begin errors++; $display("FAIL route_rv1 got %0h exp 2", bus.ch_rvalid_o); end
    checks++; if (bus.ch_rdata_o !== 64'hAAAA_5555_0000_0000) begin errors++; $display("FAIL route_rd1 got %0h exp aaaa555500000000", bus.ch_rdata_o); end
    drive(2'b00, 1'b0, 1'b1, 32'h1234_5678);
    checks++; if (bus.ch_rvalid_o !== 2'b01) begin errors++; $display("FAIL route_rv0 got %0h exp 1", bus.ch_rvalid_o); end
    checks++; if (bus.ch_rdata_o !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL route_rd0 got %0h exp 12345678", bus.ch_rdata_o); end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.out_cnt_o !== '0) begin errors++; $display("FAIL route_cnt got %0d exp 0", bus.out_cnt_o); end
  endtask

  task automatic test_err();
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checks++; if (bus.ch_rvalid_o !== '0) begin errors++; $display("FAIL err_rvalid got %0h exp 0", bus.ch_rvalid_o); end
    checks++; if (bus.ch_rdata_o !== '0) begin errors++; $display("FAIL err_rdata got %0h exp 0", bus.ch_rdata_o); end
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky%0d got %0h exp 1", i, bus.err_o); end
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %0h exp 0", bus.err_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'b01, 1'b1, 1'b0, 32'h0);
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.out_cnt_o !== CW'(3)) begin errors++; $display("FAIL mid_cnt3 got %0d exp 3", bus.out_cnt_o); end
    drive(2'b11, 1'b1, 1'b1, 32'h7777_7777);
    rst = 1'b1;
    #1;
    checks++; if (bus.m_req_o !== 1'b0) begin errors++; $display("FAIL mid_mreq got %0h exp 0", bus.m_req_o); end
    checks++; if (bus.ch_rvalid_o !== '0) begin errors++; $display("FAIL mid_rvalid got %0h exp 0", bus.ch_rvalid_o); end
    checks++; if (bus.m_wdata_o !== '0) begin errors++; $display("FAIL mid_wdata got %0h exp 0", bus.m_wdata_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.ch_req_i   = '0;
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    #1;
    checks++; if (bus.out_cnt_o !== '0) begin errors++; $display("FAIL mid_cnt0 got %0d exp 0", bus.out_cnt_o); end
    drive(2'b00, 1'b0, 1'b1, 32'h1111_2222);
    checks++; if (bus.ch_rvalid_o !== '0) begin errors++; $display("FAIL mid_stale_rv got %0h exp 0", bus.ch_rvalid_o); end
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL mid_stale_err got %0h exp 1", bus.err_o); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] req;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      req = NCH'($urandom_range(0, (1 << NCH) - 1));
      if (lock_m >= 0) req[lock_m] = 1'b1;
      bus.ch_req_i   = req;
      bus.m_gnt_i    = ($urandom_range(0, 3) != 0);
      bus.m_rvalid_i = (q_m.size() > 0) && ($urandom_range(0, 2) != 0);
      bus.m_rdata_i  = $urandom;
      bus.ch_we_i    = NCH'($urandom);
      bus.ch_be_i    = (NCH*DW/8)'($urandom);
      for (int k = 0; k < NCH; k++) begin
        bus.ch_addr_i[k*AW +: AW]  = $urandom;
        bus.ch_wdata_i[k*DW +: DW] = $urandom;
      end
      #1;
      model_eval();
      checks++; if (bus.m_req_o !== exp_mreq) begin errors++; $display("FAIL rnd_mreq c%0d got %0h exp %0h", cyc, bus.m_req_o, exp_mreq); end
      checks++; if (bus.ch_gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %0h exp %0h", cyc, bus.ch_gnt_o, exp_gnt); end
      checks++; if ({bus.m_addr_o, bus.m_we_o, bus.m_be_o, bus.m_wdata_o} !== {exp_addr, exp_we, exp_be, exp_wdata}) begin
        errors++; $display("FAIL rnd_fields c%0d got %0h/%0h exp %0h/%0h", cyc, bus.m_addr_o, bus.m_wdata_o, exp_addr, exp_wdata);
      end
      checks++; if (bus.ch_rvalid_o !== exp_rvalid) begin errors++; $display("FAIL rnd_rvalid c%0d got %0h exp %0h", cyc, bus.ch_rvalid_o, exp_rvalid); end
      checks++; if (bus.ch_rdata_o !== exp_rdata) begin errors++; $display("FAIL rnd_rdata c%0d got %0h exp %0h", cyc, bus.ch_rdata_o, exp_rdata); end
      checks++; if (bus.out_cnt_o !== exp_cnt) begin errors++; $display("FAIL rnd_cnt c%0d got %0d exp %0d", cyc, bus.out_cnt_o, exp_cnt); end
      checks++; if (bus.err_o !== exp_err) begin errors++; $display("FAIL rnd_err c%0d got %0h exp %0h", cyc, bus.err_o, exp_err); end
      model_commit();
    end
  endtask

  initial begin
    bus.ch_req_i   = '0;
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = '0;
    bus.ch_addr_i  = '0;
    bus.ch_we_i    = '0;
    bus.ch_be_i    = '0;
    bus.ch_wdata_i = '0;
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_routing();
    test_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
